sdram_burst_sched: RTL and testbench

Single-clock burst scheduler between the user-side write/read FIFOs and the SDRAM command controller. It watches both FIFO fill levels and issues one full-burst write or read request at a time, using a req/ack/done handshake. It generates wrapping SDRAM burst addresses inside a configurable region and tracks how many words are stored but not yet read back. It is the parametrised successor of the fixed-threshold write/read trigger logic, and adds round-robin arbitration, address generation, region-occupancy tracking and a sticky overflow flag.

---
 rtl/sdram_burst_sched.sv | 172 +++++++++++++++++
 tb/tb_sdram_burst_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sched.sv
// Burst scheduler between user FIFOs and the SDRAM controller.
// Round-robin write/read bursts with wrapping region addresses.
module sdram_burst_sched #(
  parameter int ADDR_W       = 22,
  parameter int LEVEL_W      = 11,
  parameter int FIFO_DEPTH   = 1024,
  parameter int BURST_LEN    = 256,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 4096,
  parameter int RD_READY_LVL = 250
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] wfifo_level,
  input  logic [LEVEL_W-1:0] rfifo_level,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  input  logic               wr_ack,
  input  logic               wr_done,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_ack,
  input  logic               rd_done,
  output logic [ADDR_W:0]    fill_words,
  output logic               rfifo_rd_ready,
  output logic               wfifo_ovf
);

  localparam logic [ADDR_W:0] L_BURST =
    (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] L_WR_MAX =
    (ADDR_W+1)'(REGION_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0] L_BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_END =
    ADDR_W'(BASE_ADDR + REGION_WORDS);
  localparam logic [ADDR_W-1:0] L_STEP =
    ADDR_W'(BURST_LEN);
  localparam logic [LEVEL_W-1:0] L_LVL_BURST =
    LEVEL_W'(BURST_LEN);
  localparam logic [LEVEL_W-1:0] L_RD_ROOM =
    LEVEL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [LEVEL_W-1:0] L_DEPTH =
    LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] L_RDY =
    LEVEL_W'(RD_READY_LVL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_BUSY,
    S_RD_REQ,
    S_RD_BUSY
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_wr;
  logic                r_wr_req;
  logic                r_rd_req;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W:0]     r_fill;
  logic                r_rdy;
  logic                r_ovf;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_wr_fin;
  logic                w_rd_fin;
  logic [ADDR_W-1:0]   w_wr_inc;
  logic [ADDR_W-1:0]   w_rd_inc;

  // Next state, burst eligibility and completion strobes
  always_comb begin
    w_next   = r_state;
    w_wr_fin = 1'b0;
    w_rd_fin = 1'b0;
    w_wr_ok  = enable
            && (wfifo_level >= L_LVL_BURST)
            && (r_fill <= L_WR_MAX);
    w_rd_ok  = enable
            && (rfifo_level <= L_RD_ROOM)
            && (r_fill >= L_BURST);
    w_wr_inc = r_wr_addr + L_STEP;
    w_rd_inc = r_rd_addr + L_STEP;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_ok && (!w_rd_ok || !r_last_wr))
          w_next = S_WR_REQ;
        else if (w_rd_ok)
          w_next = S_RD_REQ;
      end
      S_WR_REQ: begin
        if (wr_ack) begin
          w_wr_fin = wr_done;
          w_next   = wr_done ? S_IDLE : S_WR_BUSY;
        end
      end
      S_WR_BUSY: begin
        if (wr_done) begin
          w_wr_fin = 1'b1;
          w_next   = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (rd_ack) begin
          w_rd_fin = rd_done;
          w_next   = rd_done ? S_IDLE : S_RD_BUSY;
        end
      end
      S_RD_BUSY: begin
        if (rd_done) begin
          w_rd_fin = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered request outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_req <= (w_next == S_WR_REQ);
      r_rd_req <= (w_next == S_RD_REQ);
    end
  end

  // Address advance, occupancy and last-direction on completion
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= L_BASE;
      r_rd_addr <= L_BASE;
      r_fill    <= '0;
      r_last_wr <= 1'b0;
    end else if (w_wr_fin) begin
      r_wr_addr <= (w_wr_inc == L_END) ? L_BASE : w_wr_inc;
      r_fill    <= r_fill + L_BURST;
      r_last_wr <= 1'b1;
    end else if (w_rd_fin) begin
      r_rd_addr <= (w_rd_inc == L_END) ? L_BASE : w_rd_inc;
      r_fill    <= r_fill - L_BURST;
      r_last_wr <= 1'b0;
    end
  end

  // Sticky read-release and write-overflow flags
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_rdy <= r_rdy | (rfifo_level >= L_RDY);
      r_ovf <= r_ovf | (wfifo_level >= L_DEPTH);
    end
  end

  assign wr_req         = r_wr_req;
  assign rd_req         = r_rd_req;
  assign wr_addr        = r_wr_addr;
  assign rd_addr        = r_rd_addr;
  assign fill_words     = r_fill;
  assign rfifo_rd_ready = r_rdy;
  assign wfifo_ovf      = r_ovf;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched (1024-word region).
// Checks arbitration, wrap, guards, handshake, flags, reset.
module tb_sdram_burst_sched;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] wfifo_level = '0;
  logic [10:0] rfifo_level = '0;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic        wr_ack = 1'b0;
  logic        wr_done = 1'b0;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic        rd_done = 1'b0;
  logic [22:0] fill_words;
  logic        rfifo_rd_ready;
  logic        wfifo_ovf;

  int n_checks = 0;
  int n_err = 0;

  sdram_burst_sched #(
    .REGION_WORDS(1024)
  ) dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .enable(enable),
    .wfifo_level(wfifo_level),
    .rfifo_level(rfifo_level),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_ack(wr_ack),
    .wr_done(wr_done),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_done(rd_done),
    .fill_words(fill_words),
    .rfifo_rd_ready(rfifo_rd_ready),
    .wfifo_ovf(wfifo_ovf)
  );

  always #5 sclk = ~sclk;

  task automatic step;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_req"}, 32'(wr_req), 0);
    chk({tag, "_rd_req"}, 32'(rd_req), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_fill"}, 32'(fill_words), 0);
    chk({tag, "_rdy"}, 32'(rfifo_rd_ready), 0);
    chk({tag, "_ovf"}, 32'(wfifo_ovf), 0);
  endtask

  task automatic wr_burst(input logic [31:0] a);
    for (int i = 0; i < 10 && !wr_req; i++) step;
    chk("wr_req_rise", 32'(wr_req), 1);
    chk("wr_addr", 32'(wr_addr), a);
    chk("wr_excl_rd", 32'(rd_req), 0);
    wr_ack = 1'b1;
    step;
    wr_ack = 1'b0;
    chk("wr_req_drop", 32'(wr_req), 0);
    wr_done = 1'b1;
    step;
    wr_done = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a);
    for (int i = 0; i < 10 && !rd_req; i++) step;
    chk("rd_req_rise", 32'(rd_req), 1);
    chk("rd_addr", 32'(rd_addr), a);
    chk("rd_excl_wr", 32'(wr_req), 0);
    rd_ack = 1'b1;
    step;
    rd_ack = 1'b0;
    chk("rd_req_drop", 32'(rd_req), 0);
    rd_done = 1'b1;
    step;
    rd_done = 1'b0;
  endtask

  task automatic no_req(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step;
      seen = seen | wr_req | rd_req;
    end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    chk_reset_vals("rst");
    step;
    rst_n = 1'b1;

    // first write: request, ack, done three cycles later
    wfifo_level = 11'd256;
    rfifo_level = 11'd0;
    enable = 1'b1;
    step;
    chk("t1_wr_req", 32'(wr_req), 1);
    chk("t1_rd_req", 32'(rd_req), 0);
    chk("t1_wr_addr", 32'(wr_addr), 0);
    wr_ack = 1'b1;
    step;
    wr_ack = 1'b0;
    chk("t1_ack_drop", 32'(wr_req), 0);
    step;
    step;
    chk("t1_busy_fill", 32'(fill_words), 0);
    wr_done = 1'b1;
    step;
    wr_done = 1'b0;
    chk("t1_fill", 32'(fill_words), 256);
    chk("t1_wr_addr2", 32'(wr_addr), 256);
    chk("t1_gap_wr", 32'(wr_req), 0);
    chk("t1_gap_rd", 32'(rd_req), 0);
    enable = 1'b0;
    no_req("t1_disabled", 3);

    // same-cycle ack and done, reads blocked by full rfifo
    enable = 1'b1;
    wfifo_level = 11'd300;
    rfifo_level = 11'd1000;
    step;
    chk("t2_wr_req", 32'(wr_req), 1);
    chk("t2_wr_addr", 32'(wr_addr), 256);
    wr_ack = 1'b1;
    wr_done = 1'b1;
    step;
    wr_ack = 1'b0;
    wr_done = 1'b0;
    chk("t2_req_low", 32'(wr_req), 0);
    chk("t2_fill", 32'(fill_words), 512);
    chk("t2_wr_addr2", 32'(wr_addr), 512);

    // tie after a write goes to read, then back to write
    rfifo_level = 11'd0;
    step;
    chk("tie_rd_req", 32'(rd_req), 1);
    chk("tie_wr_req", 32'(wr_req), 0);
    rd_burst(0);
    chk("tie_fill", 32'(fill_words), 256);
    chk("tie_rd_addr", 32'(rd_addr), 256);
    step;
    chk("tie2_wr_req", 32'(wr_req), 1);
    chk("tie2_rd_req", 32'(rd_req), 0);
    wr_burst(512);
    chk("tie2_fill", 32'(fill_words), 512);

    // fill the region, write address wraps
    rfifo_level = 11'd1000;
    wr_burst(768);
    chk("wrap_wr_addr", 32'(wr_addr), 0);
    chk("fill_768", 32'(fill_words), 768);
    wr_burst(0);
    chk("fill_full", 32'(fill_words), 1024);
    chk("wr_addr_256", 32'(wr_addr), 256);
    wfifo_level = 11'd1000;
    no_req("full_guard", 5);
    chk("ovf_below", 32'(wfifo_ovf), 0);

    // drain the region, read address wraps
    wfifo_level = 11'd0;
    rfifo_level = 11'd0;
    rd_burst(256);
    rd_burst(512);
    rd_burst(768);
    chk("wrap_rd_addr", 32'(rd_addr), 0);
    rd_burst(0);
    chk("fill_empty", 32'(fill_words), 0);
    chk("rd_addr_256", 32'(rd_addr), 256);
    no_req("empty_guard", 5);

    // enable dropped while a read request is pending
    wfifo_level = 11'd256;
    rfifo_level = 11'd1000;
    wr_burst(256);
    wfifo_level = 11'd0;
    rfifo_level = 11'd0;
    for (int i = 0; i < 10 && !rd_req; i++) step;
    chk("en_rd_req", 32'(rd_req), 1);
    enable = 1'b0;
    step;
    step;
    chk("en_rd_held", 32'(rd_req), 1);
    rd_ack = 1'b1;
    step;
    rd_ack = 1'b0;
    chk("en_rd_drop", 32'(rd_req), 0);
    rd_done = 1'b1;
    step;
    rd_done = 1'b0;
    chk("en_fill", 32'(fill_words), 0);
    chk("en_rd_addr", 32'(rd_addr), 512);
    wfifo_level = 11'd300;
    no_req("en_off", 4);

    // write overflow flag
    wfifo_level = 11'd1024;
    chk("ovf_pre", 32'(wfifo_ovf), 0);
    step;
    chk("ovf_set", 32'(wfifo_ovf), 1);
    wfifo_level = 11'd0;
    step;
    chk("ovf_sticky", 32'(wfifo_ovf), 1);

    // async reset in WR_BUSY
    enable = 1'b1;
    wfifo_level = 11'd300;
    rfifo_level = 11'd1000;
    for (int i = 0; i < 10 && !wr_req; i++) step;
    chk("rst_wr_req", 32'(wr_req), 1);
    chk("rst_rdy_pre", 32'(rfifo_rd_ready), 1);
    wr_ack = 1'b1;
    step;
    wr_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    step;
    enable = 1'b0;
    rst_n = 1'b1;
    rfifo_level = 11'd0;
    wfifo_level = 11'd0;
    step;
    chk_reset_vals("post_rst");

    // sticky read-ready flag threshold
    rfifo_level = 11'd249;
    step;
    step;
    chk("rdy_249", 32'(rfifo_rd_ready), 0);
    rfifo_level = 11'd250;
    step;
    chk("rdy_250", 32'(rfifo_rd_ready), 1);
    rfifo_level = 11'd0;
    step;
    step;
    chk("rdy_sticky", 32'(rfifo_rd_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
